// File: rtl/gspa_pkg.sv
// rtl/gspa_pkg.sv - shared constants, state encoding and helpers for the GSPA sequencer
package gspa_pkg;

  localparam int GSPA_N_BLADES = 32;
  localparam int GSPA_IDX_W    = 5;

  // Encodings are fixed so debug/trace logic can decode the raw state bits
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } gspa_state_t;

  // One-hot vector with only bit idx set, used to retire an issued blade from the mask
  function automatic logic [GSPA_N_BLADES-1:0] gspa_onehot(input logic [GSPA_IDX_W-1:0] idx);
    logic [GSPA_N_BLADES-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/gspa_blade_pick.sv
// rtl/gspa_blade_pick.sv - lowest-set-bit picker over the blade mask
module gspa_blade_pick
  import gspa_pkg::*;
(
  input  logic [GSPA_N_BLADES-1:0] mask,
  output logic [GSPA_IDX_W-1:0]    idx,
  output logic                     any,
  output logic                     last
);

  // Priority encoder: scanning downwards leaves the lowest set index in idx
  always_comb begin
    idx = '0;
    for (int i = GSPA_N_BLADES - 1; i >= 0; i--) begin
      if (mask[i]) idx = GSPA_IDX_W'(i);
    end
  end

  // last is true when exactly one bit remains (clearing the lowest bit empties the mask)
  always_comb begin
    any  = |mask;
    last = any && ((mask & (mask - GSPA_N_BLADES'(1))) == '0);
  end

endmodule

// File: rtl/gspa_score_seq.sv
// rtl/gspa_score_seq.sv - grade-sparse query sequencer driving a PIM bank array for a scalar score
module gspa_score_seq
  import gspa_pkg::*;
#(
  parameter int N_BLADES = 32,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         q_valid,
  output logic                         q_ready,
  input  logic [N_BLADES*DATA_W-1:0]   q_data,
  input  logic [TAG_W-1:0]             q_tag,
  output logic [DATA_W-1:0]            pim_query,
  output logic [GSPA_IDX_W-1:0]        pim_blade_idx,
  output logic                         pim_cmd_score,
  input  logic [DATA_W-1:0]            pim_scalar,
  output logic                         s_valid,
  input  logic                         s_ready,
  output logic [DATA_W-1:0]            s_score,
  output logic [TAG_W-1:0]             s_tag,
  output logic [5:0]                   s_nnz,
  output logic                         busy
);

  gspa_state_t                 state;
  logic [N_BLADES*DATA_W-1:0]  q_reg;
  logic [TAG_W-1:0]            tag_reg;
  logic [N_BLADES-1:0]         mask;
  logic [N_BLADES-1:0]         new_mask;
  logic [N_BLADES-1:0]         pick_mask;
  logic [N_BLADES*DATA_W-1:0]  pick_src;
  logic [DATA_W-1:0]           pick_val;
  logic [GSPA_IDX_W-1:0]       pick_idx;
  logic                        pick_any;
  logic                        pick_last;
  logic                        issue_last;
  logic                        issued_d;
  logic [DATA_W-1:0]           acc;
  logic [5:0]                  nnz;
  logic                        accept;

  assign accept = q_valid && q_ready;

  // Non-zero blade mask of the query currently offered on q_data
  always_comb begin
    new_mask = '0;
    for (int i = 0; i < N_BLADES; i++) begin
      new_mask[i] = (q_data[i*DATA_W +: DATA_W] != '0);
    end
  end

  // In IDLE the first blade is picked straight from the incoming query so it can be
  // broadcast in the cycle right after accept; afterwards the latched copy is used
  assign pick_mask = (state == S_IDLE) ? new_mask : mask;
  assign pick_src  = (state == S_IDLE) ? q_data   : q_reg;
  assign pick_val  = pick_src[pick_idx*DATA_W +: DATA_W];

  gspa_blade_pick u_pick (
    .mask (pick_mask),
    .idx  (pick_idx),
    .any  (pick_any),
    .last (pick_last)
  );

  // Control FSM with registered handshake and PIM broadcast outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      q_reg         <= '0;
      tag_reg       <= '0;
      mask          <= '0;
      issue_last    <= 1'b0;
      q_ready       <= 1'b1;
      s_valid       <= 1'b0;
      busy          <= 1'b0;
      pim_cmd_score <= 1'b0;
      pim_query     <= '0;
      pim_blade_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            q_reg   <= q_data;
            tag_reg <= q_tag;
            q_ready <= 1'b0;
            busy    <= 1'b1;
            if (pick_any) begin
              state         <= S_ISSUE;
              pim_cmd_score <= 1'b1;
              pim_blade_idx <= pick_idx;
              pim_query     <= pick_val;
              mask          <= new_mask & ~gspa_onehot(pick_idx);
              issue_last    <= pick_last;
            end else begin
              state   <= S_DONE;
              s_valid <= 1'b1;
              mask    <= '0;
            end
          end
        end
        S_ISSUE: begin
          if (issue_last || !pick_any) begin
            state         <= S_DRAIN;
            pim_cmd_score <= 1'b0;
            pim_blade_idx <= '0;
            pim_query     <= '0;
            issue_last    <= 1'b0;
          end else begin
            pim_blade_idx <= pick_idx;
            pim_query     <= pick_val;
            mask          <= mask & ~gspa_onehot(pick_idx);
            issue_last    <= pick_last;
          end
        end
        S_DRAIN: begin
          state   <= S_DONE;
          s_valid <= 1'b1;
        end
        S_DONE: begin
          if (s_ready) begin
            state   <= S_IDLE;
            s_valid <= 1'b0;
            busy    <= 1'b0;
            q_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Accumulate the array result one cycle behind each broadcast, and count issued blades
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      nnz      <= '0;
      issued_d <= 1'b0;
    end else begin
      issued_d <= pim_cmd_score;
      if (accept) begin
        acc <= '0;
        nnz <= '0;
      end else begin
        if (issued_d)      acc <= acc + pim_scalar;
        if (pim_cmd_score) nnz <= nnz + 6'd1;
      end
    end
  end

  assign s_score = acc;
  assign s_tag   = tag_reg;
  assign s_nnz   = nnz;

endmodule

// File: tb/tb_gspa_score_seq.sv
// tb/tb_gspa_score_seq.sv - self-checking bench for gspa_score_seq
module tb_gspa_score_seq;

  localparam int NB = 32;
  localparam int DW = 32;
  localparam int TW = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             q_valid;
  logic             q_ready;
  logic [NB*DW-1:0] q_data;
  logic [TW-1:0]    q_tag;
  logic [DW-1:0]    pim_query;
  logic [4:0]       pim_blade_idx;
  logic             pim_cmd_score;
  logic [DW-1:0]    pim_scalar;
  logic             s_valid;
  logic             s_ready;
  logic [DW-1:0]    s_score;
  logic [TW-1:0]    s_tag;
  logic [5:0]       s_nnz;
  logic             busy;

  always #5 clk = ~clk;

  gspa_score_seq #(.N_BLADES(NB), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .q_valid       (q_valid),
    .q_ready       (q_ready),
    .q_data        (q_data),
    .q_tag         (q_tag),
    .pim_query     (pim_query),
    .pim_blade_idx (pim_blade_idx),
    .pim_cmd_score (pim_cmd_score),
    .pim_scalar    (pim_scalar),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_score       (s_score),
    .s_tag         (s_tag),
    .s_nnz         (s_nnz),
    .busy          (busy)
  );

  // Behavioural PIM array: registers Q*V[idx] one cycle after enable, holds otherwise
  logic [DW-1:0] vvec [NB];
  logic [DW-1:0] pim_part = '0;
  always @(posedge clk) if (pim_cmd_score) pim_part <= pim_query * vvec[pim_blade_idx];
  assign pim_scalar = pim_part;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    string       name;
    logic [31:0] q [NB];
    logic [7:0]  tag;
    int          vmode;
    logic [31:0] exp_score;
    int          exp_nnz;
    int          exp_lat;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic set_v(input int mode);
    for (int j = 0; j < NB; j++) begin
      case (mode)
        0:       vvec[j] = 32'(j);
        1:       vvec[j] = 32'd10;
        default: vvec[j] = 32'd1;
      endcase
    end
  endtask

  // Reference: score = sum over non-zero blades of Q[i]*V[i] mod 2^32
  task automatic ref_model(input logic [31:0] q [NB], output logic [31:0] score,
                           output int nnz, output int lat);
    score = '0;
    nnz   = 0;
    for (int i = 0; i < NB; i++) begin
      if (q[i] != 32'd0) begin
        score = score + q[i] * vvec[i];
        nnz++;
      end
    end
    lat = (nnz == 0) ? 1 : nnz + 2;
  endtask

  task automatic check_reset(input string name);
    check({name, "/ctl"}, {59'd0, q_ready, s_valid, busy, pim_cmd_score, pim_blade_idx != 5'd0},
          {59'd0, 5'b10000});
    check({name, "/score"}, s_score, 0);
    check({name, "/tag_nnz"}, {s_tag, s_nnz}, 0);
    check({name, "/pim_query"}, pim_query, 0);
  endtask

  // Called at a negedge while IDLE; returns at the negedge where s_valid was seen,
  // or one cycle later (back in IDLE) when s_ready is high
  task automatic do_query(input string name, input logic [31:0] q [NB], input logic [7:0] tag,
                          input logic [31:0] exp_score, input int exp_nnz, input int exp_lat);
    int exp_idx [$];
    int cyc;
    int lat;
    int n_iss;
    bit order_ok;
    for (int i = 0; i < NB; i++) if (q[i] != 32'd0) exp_idx.push_back(i);
    for (int i = 0; i < NB; i++) q_data[i*DW +: DW] = q[i];
    q_tag   = tag;
    q_valid = 1'b1;
    check({name, "/accept_ready"}, q_ready, 1);
    @(posedge clk);
    @(negedge clk);
    q_valid = 1'b0;
    q_data  = {NB{$urandom}};
    q_tag   = 8'($urandom);
    cyc      = 1;
    lat      = -1;
    n_iss    = 0;
    order_ok = 1'b1;
    while (cyc <= 100) begin
      if (pim_cmd_score) begin
        if (n_iss >= exp_idx.size()) order_ok = 1'b0;
        else if (int'(pim_blade_idx) != exp_idx[n_iss] || pim_query != q[pim_blade_idx] ||
                 cyc != n_iss + 1) order_ok = 1'b0;
        n_iss++;
      end
      if (s_valid) begin
        lat = cyc;
        break;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check({name, "/latency"}, lat, exp_lat);
    check({name, "/issue_count"}, n_iss, exp_idx.size());
    check({name, "/issue_order"}, order_ok, 1);
    check({name, "/score"}, s_score, exp_score);
    check({name, "/tag"}, s_tag, tag);
    check({name, "/nnz"}, s_nnz, exp_nnz);
    check({name, "/ready_busy"}, {q_ready, busy}, 2'b01);
    if (s_ready) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rq [NB];
    logic [31:0] r_score;
    int          r_nnz;
    int          r_lat;
    bit          stable;

    q_valid = 1'b0;
    q_data  = '0;
    q_tag   = '0;
    s_ready = 1'b1;
    set_v(0);
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 4; t++) for (int i = 0; i < NB; i++) tbl[t].q[i] = '0;
    tbl[0].name = "dense";  tbl[0].tag = 8'hA1; tbl[0].vmode = 0;
    for (int i = 0; i < NB; i++) tbl[0].q[i] = 32'd1;
    tbl[0].exp_score = 32'd496; tbl[0].exp_nnz = 32; tbl[0].exp_lat = 34;
    tbl[1].name = "sparse"; tbl[1].tag = 8'hB2; tbl[1].vmode = 1;
    tbl[1].q[3] = 32'd2; tbl[1].q[17] = 32'hFFFF_FFFF; tbl[1].q[31] = 32'd5;
    tbl[1].exp_score = 32'd60; tbl[1].exp_nnz = 3; tbl[1].exp_lat = 5;
    tbl[2].name = "zero";   tbl[2].tag = 8'hC3; tbl[2].vmode = 1;
    tbl[2].exp_score = 32'd0; tbl[2].exp_nnz = 0; tbl[2].exp_lat = 1;
    tbl[3].name = "overflow"; tbl[3].tag = 8'hD4; tbl[3].vmode = 2;
    tbl[3].q[2] = 32'h7FFF_FFFF; tbl[3].q[9] = 32'd1;
    tbl[3].exp_score = 32'h8000_0000; tbl[3].exp_nnz = 2; tbl[3].exp_lat = 4;

    for (int t = 0; t < 4; t++) begin
      set_v(tbl[t].vmode);
      do_query(tbl[t].name, tbl[t].q, tbl[t].tag, tbl[t].exp_score, tbl[t].exp_nnz, tbl[t].exp_lat);
    end

    // Back-pressure: DONE held for 10 cycles with stable outputs, then a follow-on query
    set_v(1);
    s_ready = 1'b0;
    do_query("bp", tbl[1].q, 8'h5C, 32'd60, 3, 5);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if ({s_valid, q_ready, s_score, s_tag, s_nnz} !== {1'b1, 1'b0, 32'd60, 8'h5C, 6'd3})
        stable = 1'b0;
    end
    check("bp/hold_stable", stable, 1);
    s_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp/release", {q_ready, s_valid}, 2'b10);
    set_v(2);
    do_query("bp_next", tbl[3].q, 8'h6D, 32'h8000_0000, 2, 4);

    // Reset during ISSUE of a dense query
    set_v(0);
    for (int i = 0; i < NB; i++) q_data[i*DW +: DW] = 32'd1;
    q_tag   = 8'hEE;
    q_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    q_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid/issuing", {pim_cmd_score, pim_blade_idx}, {1'b1, 5'd3});
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_v(1);
    do_query("after_rst", tbl[1].q, 8'h42, 32'd60, 3, 5);

    // Randomized queries against the reference model
    for (int n = 0; n < 24; n++) begin
      for (int j = 0; j < NB; j++) vvec[j] = $urandom;
      for (int i = 0; i < NB; i++) begin
        case (n % 4)
          0:       rq[i] = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
          1:       rq[i] = ($urandom_range(0, 1) == 0) ? $urandom : 32'd0;
          2:       rq[i] = 32'($urandom_range(0, 3));
          default: rq[i] = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(1, 9)) : 32'd0;
        endcase
      end
      ref_model(rq, r_score, r_nnz, r_lat);
      do_query($sformatf("rand%0d", n), rq, 8'($urandom), r_score, r_nnz, r_lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
